// File: rtl/tone_bit_fetch.sv
// Pulls bytes from a FIFO into a 24-bit bit buffer and hands out
// variable-length (0..15 bit) tone words, LSB-first.
module tone_bit_fetch #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty_i,
  output logic              fifo_re_o,
  input  logic [DWIDTH-1:0] fifo_data_i,
  input  logic              req_i,
  input  logic [3:0]        bits_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [14:0]       bits_o,
  output logic [4:0]        resid_o,
  output logic              underrun_o
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPT, EMIT} state_t;

  state_t      state_reg, state_next;
  logic [23:0] bit_buf_reg, bit_buf_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [3:0]  len_reg, len_next;
  logic        under_reg, under_next;
  logic [4:0]  cnt_eff;
  logic [4:0]  cnt_capt;
  logic [14:0] emit_bits;

  // Keep only the lowest len_reg buffered bits for the output word.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_mask
      assign emit_bits[gi] = bit_buf_reg[gi] & (len_reg > 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      bit_buf_reg <= '0;
      cnt_reg     <= '0;
      len_reg     <= '0;
      under_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_buf_reg <= bit_buf_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      under_reg   <= under_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_buf_next = bit_buf_reg;
    cnt_next     = cnt_reg;
    len_next     = len_reg;
    under_next   = under_reg;
    fifo_re_o    = 1'b0;
    valid_o      = 1'b0;
    bits_o       = '0;
    cnt_capt     = cnt_reg + 5'd8;
    // A same-cycle flush empties the buffer before the request is judged.
    cnt_eff      = flush_i ? 5'd0 : cnt_reg;

    case (state_reg)
      IDLE: begin
        if (flush_i) begin
          bit_buf_next = '0;
          cnt_next     = '0;
          under_next   = 1'b0;
        end
        if (req_i) begin
          len_next   = bits_i;
          state_next = ({1'b0, bits_i} <= cnt_eff) ? EMIT : FETCH;
        end
      end
      FETCH: begin
        fifo_re_o = ~fifo_empty_i;
        if (fifo_empty_i) begin
          under_next = 1'b1;
        end else begin
          state_next = CAPT;
        end
      end
      CAPT: begin
        // Count is below 15 here, so the new byte always fits in 24 bits.
        bit_buf_next = bit_buf_reg | (24'(fifo_data_i) << cnt_reg);
        cnt_next     = cnt_capt;
        state_next   = (cnt_capt >= {1'b0, len_reg}) ? EMIT : FETCH;
      end
      EMIT: begin
        valid_o      = 1'b1;
        bits_o       = emit_bits;
        bit_buf_next = bit_buf_reg >> len_reg;
        cnt_next     = cnt_reg - {1'b0, len_reg};
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready_o    = (state_reg == IDLE);
  assign resid_o    = cnt_reg;
  assign underrun_o = under_reg;

endmodule

// File: tb/tb_tone_bit_fetch.sv
// Directed and randomized checks of tone_bit_fetch against a bit-queue
// reference model fed from a simple FIFO model.
module tb_tone_bit_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_empty_i;
  logic        fifo_re_o;
  logic [7:0]  fifo_data_i = 8'h00;
  logic        req_i = 1'b0;
  logic [3:0]  bits_i = 4'd0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic [14:0] bits_o;
  logic [4:0]  resid_o;
  logic        underrun_o;

  int errors = 0;
  int checks = 0;

  logic [7:0]  fifo_mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  // Reference model: bytes not yet pulled, and buffered bits in consume order.
  byte unsigned model_src[$];
  bit           model_bits[$];
  bit           model_under = 1'b0;

  int          needed, lat, reads, pulses;
  logic [31:0] exp_val;

  tone_bit_fetch #(.DWIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty_i (fifo_empty_i),
    .fifo_re_o    (fifo_re_o),
    .fifo_data_i  (fifo_data_i),
    .req_i        (req_i),
    .bits_i       (bits_i),
    .ready_o      (ready_o),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .bits_o       (bits_o),
    .resid_o      (resid_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_re_o && (rd_ptr != wr_ptr)) begin
      fifo_data_i <= fifo_mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    if (wr_ptr < 1024) begin
      fifo_mem[wr_ptr] = v;
      wr_ptr++;
      model_src.push_back(v);
    end
  endtask

  task automatic model_take(input int b, output int nbytes, output logic [31:0] val);
    byte unsigned v;
    nbytes = 0;
    val    = '0;
    while (model_bits.size() < b && model_src.size() > 0) begin
      v = model_src.pop_front();
      for (int k = 0; k < 8; k++) model_bits.push_back(v[k]);
      nbytes++;
    end
    for (int k = 0; k < b; k++) val[k] = model_bits.pop_front();
  endtask

  task automatic do_req(input int b, input bit fl, input string tag);
    int          nb, lt, rd;
    logic [31:0] ev;
    if (fl) begin
      model_bits.delete();
      model_under = 1'b0;
    end
    model_take(b, nb, ev);
    @(negedge clk);
    chk({tag, "/ready"}, 32'(ready_o), 32'd1);
    req_i   = 1'b1;
    bits_i  = 4'(b);
    flush_i = fl;
    @(posedge clk);
    #1;
    req_i   = 1'b0;
    flush_i = 1'b0;
    lt = 0;
    rd = 0;
    do begin
      @(negedge clk);
      lt++;
      if (fifo_re_o) rd++;
    end while (!valid_o && lt < 100);
    chk({tag, "/latency"}, 32'(lt), 32'(1 + 2 * nb));
    chk({tag, "/reads"}, 32'(rd), 32'(nb));
    chk({tag, "/bits"}, 32'(bits_o), ev);
    chk({tag, "/underrun"}, 32'(underrun_o), 32'(model_under));
    @(negedge clk);
    chk({tag, "/resid"}, 32'(resid_o), 32'(model_bits.size()));
    chk({tag, "/valid_off"}, 32'(valid_o), 32'd0);
    $display("txn %s B=%0d flush=%0d bits=%h lat=%0d reads=%0d resid=%0d",
             tag, b, fl, ev, lt, rd, model_bits.size());
  endtask

  task automatic do_flush(input string tag);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    model_bits.delete();
    model_under = 1'b0;
    @(negedge clk);
    chk({tag, "/resid"}, 32'(resid_o), 32'd0);
    chk({tag, "/underrun"}, 32'(underrun_o), 32'd0);
    $display("txn %s flush resid=%0d underrun=%0d", tag, resid_o, underrun_o);
  endtask

  initial begin
    int b;
    bit fl;
    int avail;

    repeat (3) @(negedge clk);
    chk("rst/ready", 32'(ready_o), 32'd1);
    chk("rst/resid", 32'(resid_o), 32'd0);
    chk("rst/valid", 32'(valid_o), 32'd0);
    chk("rst/bits", 32'(bits_o), 32'd0);
    chk("rst/re", 32'(fifo_re_o), 32'd0);
    chk("rst/underrun", 32'(underrun_o), 32'd0);
    reset = 1'b1;

    push(8'hA5);
    do_req(3, 1'b0, "a5_b3");
    do_req(5, 1'b0, "a5_b5");

    push(8'h34);
    push(8'h12);
    do_req(15, 1'b0, "b15");
    do_flush("b15_flush");

    do_req(0, 1'b0, "b0_empty");

    // Empty FIFO: request stalls in FETCH, flags underrun, then completes.
    @(negedge clk);
    req_i  = 1'b1;
    bits_i = 4'd4;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    reads = 0;
    repeat (4) begin
      @(negedge clk);
      if (fifo_re_o) reads++;
    end
    chk("under/reads", 32'(reads), 32'd0);
    chk("under/flag", 32'(underrun_o), 32'd1);
    chk("under/valid", 32'(valid_o), 32'd0);
    chk("under/ready", 32'(ready_o), 32'd0);
    model_under = 1'b1;
    push(8'h0F);
    model_take(4, needed, exp_val);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid_o && lat < 100);
    chk("under/latency", 32'(lat), 32'd2);
    chk("under/bits", 32'(bits_o), exp_val);
    chk("under/sticky", 32'(underrun_o), 32'd1);
    @(negedge clk);
    chk("under/resid", 32'(resid_o), 32'(model_bits.size()));
    $display("txn under B=4 bits=%h lat=%0d resid=%0d", exp_val, lat, model_bits.size());
    do_req(2, 1'b0, "under_more");
    do_flush("under_flush");

    for (int i = 0; i < 30; i++) begin
      b  = int'($urandom_range(0, 15));
      fl = ($urandom_range(0, 5) == 0);
      avail = (fl ? 0 : model_bits.size()) + 8 * model_src.size();
      while (avail < b) begin
        push(8'($urandom));
        avail += 8;
      end
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      do_req(b, fl, "rnd");
    end

    // Reset asserted while the block sits in CAPT of a 12-bit request.
    push(8'h5A);
    push(8'hC3);
    @(negedge clk);
    req_i   = 1'b1;
    bits_i  = 4'd12;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    req_i   = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    chk("abort/fetch_re", 32'(fifo_re_o), 32'd1);
    @(negedge clk);
    chk("abort/capt_ready", 32'(ready_o), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort/ready", 32'(ready_o), 32'd1);
    chk("abort/resid", 32'(resid_o), 32'd0);
    chk("abort/valid", 32'(valid_o), 32'd0);
    chk("abort/bits", 32'(bits_o), 32'd0);
    chk("abort/re", 32'(fifo_re_o), 32'd0);
    chk("abort/underrun", 32'(underrun_o), 32'd0);
    pulses = 0;
    reads  = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid_o) pulses++;
      if (fifo_re_o) reads++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (valid_o) pulses++;
      if (fifo_re_o) reads++;
    end
    chk("abort/pulses", 32'(pulses), 32'd0);
    chk("abort/reads", 32'(reads), 32'd0);
    chk("abort/ready_after", 32'(ready_o), 32'd1);
    $display("txn abort pulses=%0d reads=%0d ready=%0d", pulses, reads, ready_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
